// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
//   TickIn     : divider output level, Clk-synchronous (consumer side drives)
//   HSync      : horizontal sync, level set by SYNC_POL
//   VSync      : vertical sync, level set by SYNC_POL
//   Active     : position is inside the visible area
//   PixX/PixY  : raw horizontal/vertical counter values
//   LineStart  : one-Clk pulse when the horizontal counter wraps to 0
//   FrameStart : one-Clk pulse when both counters wrap to (0,0)
// modport master : the timing generator
// modport slave  : pixel-fetch/output stages (and whoever supplies TickIn)
interface video_timing_gen_if;
  logic        TickIn;
  logic        HSync;
  logic        VSync;
  logic        Active;
  logic [10:0] PixX;
  logic [10:0] PixY;
  logic        LineStart;
  logic        FrameStart;

  modport master (
    input  TickIn,
    output HSync, VSync, Active, PixX, PixY, LineStart, FrameStart
  );

  modport slave (
    output TickIn,
    input  HSync, VSync, Active, PixX, PixY, LineStart, FrameStart
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator. Advances one pixel position per rising edge of
// the divider output (TickIn, sampled as data in the Clk domain) and emits
// registered sync/active/coordinate decode plus line/frame start strobes.
// Ports:
//   Clk : system clock
//   Rst : synchronous, active-high reset
//   vif : video_timing_gen_if.master (TickIn in; HSync, VSync, Active,
//         PixX, PixY, LineStart, FrameStart out)
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic                Clk,
  input  logic                Rst,
  video_timing_gen_if.master  vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bounds are 12 bits wide so a 2048-pixel active region still compares
  // correctly against the 11-bit counters.
  localparam logic [11:0] L_H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] L_HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] L_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] L_H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] L_V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] L_VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] L_V_LAST = 12'(V_TOTAL - 1);
  localparam logic        L_ON     = (SYNC_POL != 0);

  logic        r_tick_prev;
  logic        r_adv_d;
  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_active;
  logic [10:0] r_pix_x;
  logic [10:0] r_pix_y;
  logic        r_line_start;
  logic        r_frame_start;

  logic        w_adv;
  logic [11:0] w_hx;
  logic [11:0] w_vx;

  assign w_adv = vif.TickIn & ~r_tick_prev;
  assign w_hx  = {1'b0, r_hcnt};
  assign w_vx  = {1'b0, r_vcnt};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // TickPrev resets high so a TickIn held through reset is not an edge.
      r_tick_prev   <= 1'b1;
      r_adv_d       <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= ~L_ON;
      r_vsync       <= ~L_ON;
      r_active      <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_tick_prev <= vif.TickIn;
      r_adv_d     <= w_adv;

      if (w_adv) begin
        if (w_hx == L_H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (w_vx == L_V_LAST) ? '0 : r_vcnt + 11'd1;
        end else begin
          r_hcnt <= r_hcnt + 11'd1;
        end
      end

      // Decode uses the pre-update counters, giving one Clk of latency.
      r_active <= (w_hx < L_H_ACT) && (w_vx < L_V_ACT);
      r_hsync  <= ((w_hx >= L_HS_BEG) && (w_hx < L_HS_END)) ? L_ON : ~L_ON;
      r_vsync  <= ((w_vx >= L_VS_BEG) && (w_vx < L_VS_END)) ? L_ON : ~L_ON;
      r_pix_x  <= r_hcnt;
      r_pix_y  <= r_vcnt;

      // AdvD marks that the counters just moved, so the strobes line up with
      // the decode of the new position and never fire for the reset (0,0).
      r_line_start  <= r_adv_d && (r_hcnt == '0);
      r_frame_start <= r_adv_d && (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  assign vif.HSync      = r_hsync;
  assign vif.VSync      = r_vsync;
  assign vif.Active     = r_active;
  assign vif.PixX       = r_pix_x;
  assign vif.PixY       = r_pix_y;
  assign vif.LineStart  = r_line_start;
  assign vif.FrameStart = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen with small raster parameters
// (H 4/1/2/1, V 3/1/1/1, active-low sync). The reference model counts
// TickIn rising edges and derives the expected raster position and decode
// from that count with plain arithmetic.
module tb_video_timing_gen;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned POL = 0;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  if (HT > 2048 || VT > 2048) begin : g_size_chk
    $fatal(1, "FAIL size: raster totals exceed 2048");
  end

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  video_timing_gen_if vif ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .vif (vif)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: advances since reset, whether the previous edge advanced,
  // and the TickIn level seen at the previous edge.
  int unsigned n_adv     = 0;
  bit          adv_prev  = 0;
  bit          tick_prev = 1;
  bit          in_reset  = 1;
  int unsigned ls_cnt    = 0;
  int unsigned fs_cnt    = 0;

  function automatic logic [26:0] expect_outs(input int unsigned n, input bit advp);
    int unsigned x, y;
    logic hs, vs, act, ls, fs;
    x   = n % HT;
    y   = (n / HT) % VT;
    act = (x < HA) && (y < VA);
    hs  = (x >= HA + HF && x < HA + HF + HS) ? POL[0] : ~POL[0];
    vs  = (y >= VA + VF && y < VA + VF + VS) ? POL[0] : ~POL[0];
    ls  = advp && (x == 0);
    fs  = advp && (x == 0) && (y == 0);
    return {hs, vs, act, 11'(x), 11'(y), ls, fs};
  endfunction

  function automatic logic [26:0] observed();
    return {vif.HSync, vif.VSync, vif.Active, vif.PixX, vif.PixY,
            vif.LineStart, vif.FrameStart};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Clk: drive inputs, let the edge happen, update the model, then
  // compare every output at the following negedge.
  task automatic cycle(input bit rst, input bit tick);
    logic [26:0] exp;
    bit adv_now;
    Rst        = rst;
    vif.TickIn = tick;
    @(posedge Clk);
    if (rst) begin
      n_adv     = 0;
      adv_prev  = 0;
      tick_prev = 1;
      in_reset  = 1;
    end else begin
      in_reset  = 0;
      exp       = expect_outs(n_adv, adv_prev);
      adv_now   = tick && !tick_prev;
      n_adv     = n_adv + (adv_now ? 1 : 0);
      adv_prev  = adv_now;
      tick_prev = tick;
    end
    @(negedge Clk);
    if (in_reset) exp = {1'b1, 1'b1, 25'd0};
    chk("outs", 32'(observed()), 32'(exp));
    if (vif.LineStart)  ls_cnt++;
    if (vif.FrameStart) fs_cnt++;
  endtask

  task automatic ticks(input int unsigned n, input int unsigned hi, input int unsigned lo);
    for (int unsigned i = 0; i < n; i++) begin
      repeat (lo) cycle(0, 0);
      repeat (hi) cycle(0, 1);
    end
  endtask

  task automatic do_reset();
    repeat (2) cycle(1, 1);
    ls_cnt = 0;
    fs_cnt = 0;
  endtask

  initial begin
    vif.TickIn = 1'b1;
    @(negedge Clk);

    // Reset values with TickIn held high, then release with no edge.
    do_reset();
    chk("rst_hsync",  32'(vif.HSync),  32'd1);
    chk("rst_active", 32'(vif.Active), 32'd0);
    repeat (3) cycle(0, 1);
    chk("rel_active", 32'(vif.Active), 32'd1);
    chk("rel_pos",    32'({vif.PixX, vif.PixY}), 32'd0);
    chk("rel_ls",     32'(ls_cnt), 32'd0);

    // Line sequencing: eight ticks bring X back to 0 on line 1.
    ticks(8, 3, 3);
    chk("line_x", 32'(vif.PixX), 32'd0);
    chk("line_y", 32'(vif.PixY), 32'd1);
    chk("line_ls_cnt", 32'(ls_cnt), 32'd1);
    chk("line_fs_cnt", 32'(fs_cnt), 32'd0);

    // Frame wrap: 48 ticks from reset return to (0,0).
    do_reset();
    ticks(48, 3, 3);
    chk("frame_pos", 32'({vif.PixX, vif.PixY}), 32'd0);
    chk("frame_ls_cnt", 32'(ls_cnt), 32'd6);
    chk("frame_fs_cnt", 32'(fs_cnt), 32'd1);

    // Long-high TickIn: exactly one advance.
    do_reset();
    repeat (2)  cycle(0, 0);
    repeat (20) cycle(0, 1);
    repeat (3)  cycle(0, 0);
    chk("long_x", 32'(vif.PixX), 32'd1);

    // Latency: outputs unchanged right after edge k, updated after k+1.
    do_reset();
    repeat (2) cycle(0, 0);
    cycle(0, 1);
    chk("lat_k",  32'(vif.PixX), 32'd0);
    cycle(0, 0);
    chk("lat_k1", 32'(vif.PixX), 32'd1);

    // Reset mid-frame at (6,2), then resume on the next rising edge.
    do_reset();
    ticks(22, 3, 3);
    chk("mid_pos", 32'({vif.PixX, vif.PixY}), 32'({11'd6, 11'd2}));
    ls_cnt = 0;
    cycle(1, 0);
    chk("mid_rst_pos",  32'({vif.PixX, vif.PixY}), 32'd0);
    chk("mid_rst_sync", 32'({vif.HSync, vif.VSync}), 32'd3);
    ticks(1, 3, 3);
    chk("mid_resume_x", 32'(vif.PixX), 32'd1);
    chk("mid_no_strobe", 32'(ls_cnt), 32'd0);

    // Randomized TickIn high/low durations, occasional reset.
    do_reset();
    for (int unsigned s = 0; s < 400; s++) begin
      if ($urandom_range(0, 99) == 0) begin
        cycle(1, 1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(1, 4)) cycle(0, 0);
        repeat ($urandom_range(1, 4)) cycle(0, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator that sits directly downstream of the clock divider. It treats the divider's square-wave output as a data signal in the `Clk` domain and advances one pixel position per divider rising edge. It produces horizontal/vertical sync, an active-video flag, pixel coordinates, and line/frame start strobes for the pixel-fetch and output stages.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: horizontal sync width, in pixels
- `H_BP`, default 48: horizontal back porch, in pixels
- `V_ACTIVE`, default 480: visible lines per frame
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vertical sync width, in lines
- `V_BP`, default 33: vertical back porch, in lines
- `SYNC_POL`, default 0: asserted level of `HSync`/`VSync` (0 = active-low)
- `Clk` input 1: system clock, 100 MHz
- `Rst` input 1: synchronous, active-high reset
- `TickIn` input 1: divider output level, synchronous to `Clk`
- `HSync` output 1: horizontal sync, registered
- `VSync` output 1: vertical sync, registered
- `Active` output 1: high while the position is inside the visible area
- `PixX` output 11: horizontal counter value, 0..H_TOTAL-1
- `PixY` output 11: vertical counter value, 0..V_TOTAL-1
- `LineStart` output 1: one-`Clk` pulse when the horizontal counter wraps to 0
- `FrameStart` output 1: one-`Clk` pulse when both counters wrap to (0,0)

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Both totals must be ≤ 2048. The bench checks this at elaboration.
- Edge detect: `TickPrev` <= `TickIn` every edge, and `Adv` = `TickIn` & ~`TickPrev`.
  - Exactly one advance occurs per `TickIn` rising edge, no matter how long `TickIn` stays high.
- Counter behaviour on each edge where `Adv` = 1:
  - If `hcnt` = H_TOTAL-1: `hcnt` <= 0, and `vcnt` <= (`vcnt` = V_TOTAL-1 ? 0 : `vcnt`+1).
  - Otherwise: `hcnt` <= `hcnt`+1, and `vcnt` holds.
- Counters hold whenever `Adv` = 0.
- Decode is registered every `Clk` edge from the current counter values:
  - `Active` = (`hcnt` < H_ACTIVE) & (`vcnt` < V_ACTIVE).
  - `HSync` asserted (= SYNC_POL) for H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
  - `VSync` asserted for V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC; otherwise ~SYNC_POL.
  - `PixX` = `hcnt` and `PixY` = `vcnt` (raw values, not masked during blanking).
- Strobes:
  - `AdvD` <= `Adv`.
  - `LineStart` <= `AdvD` & (`hcnt` = 0).
  - `FrameStart` <= `AdvD` & (`hcnt` = 0) & (`vcnt` = 0).
  - Each strobe is high for exactly one `Clk`.
- Reset takes priority over everything else. On reset:
  - `hcnt`, `vcnt`, and `AdvD` go to 0.
  - `TickPrev` goes to 1, so a `TickIn` held high through reset produces no advance until a genuine rising edge.
  - Outputs: `HSync` = `VSync` = ~SYNC_POL; `Active` = 0; `PixX` = `PixY` = 0; `LineStart` = `FrameStart` = 0.
- The first edge after reset releases registers the decode of (0,0), so `Active` = 1.
  - No `FrameStart`/`LineStart` is issued for this initial position, because it was not reached by an advance.
- Reset mid-frame: the counters return to (0,0) on the same edge. No wrap strobes are generated by the reset.

## Timing
- Let edge k be the edge where `TickIn` = 1 is sampled with `TickPrev` = 0. Counters update at edge k.
- `Active`/`HSync`/`VSync`/`PixX`/`PixY` reflect the new position at edge k+1, giving 1 `Clk` of decode latency.
- `LineStart`/`FrameStart` assert at edge k+1, aligned with the outputs of the new position, and deassert at edge k+2.
- The minimum legal `TickIn` period is 2 `Clk` (high 1, low 1). Shorter periods are outside the contract.
- Each position holds for exactly one `TickIn` period. With the divider at DivVal = N, that is 2(N+1) `Clk` cycles.

## Test plan
Small parameters are used for all cases: H 4/1/2/1 (H_TOTAL = 8), V 3/1/1/1 (V_TOTAL = 6), SYNC_POL = 0, and `TickIn` toggling every 3 `Clk` unless stated otherwise.
- **Reset values:** hold `Rst` high with `TickIn` = 1 → `HSync` = `VSync` = 1, `Active` = 0, `PixX` = `PixY` = 0, no strobes. After release, with no `TickIn` edge → `Active` = 1, (0,0) held, no advance.
- **Line sequencing:** run 8 ticks → `PixX` steps 1..7,0. `Active` is high for X = 0..3. `HSync` is 0 exactly for X = 5,6. `LineStart` is a 1-`Clk` pulse when X returns to 0, with `PixY` = 1.
- **Frame wrap:** run 48 ticks from reset → `VSync` is 0 only while Y = 4. `Active` is never high for Y ≥ 3. On return to (0,0), `FrameStart` and `LineStart` pulse together for 1 `Clk`.
- **Long-high tick:** `TickIn` high for 20 `Clk`, then low → exactly one advance, with `PixX` going 0→1.
- **Reset mid-frame:** assert `Rst` for 1 `Clk` at (6,2) → next edge shows `PixX` = `PixY` = 0, `HSync` = `VSync` = 1, no strobe. Counting resumes on the next `TickIn` rising edge.
- **Latency:** probe edge k (first `TickIn` = 1 sample) → `PixX` changes at k+1, never at k.
